modmulti_iter: RTL and testbench
================================

// Module: modmulti_iter
// PURPOSE
//  Iterative parametrised Montgomery modular multiplier: result = dat1*dat2*2^-WIDTH mod mod.
//  Successor to the single-shot modmulti; adds start/done handshake, operand latching,
//  configurable bits-per-cycle (UNROLL), odd-modulus check and final conditional subtract.
//  Sits under the modexp sequencer; the operands and result are in the Montgomery domain.
// PARAMETERS
//  WIDTH   2048  operand/modulus width N in bits; R = 2^WIDTH
//  UNROLL  1     radix-2 steps per clock; WIDTH % UNROLL == 0 (elaboration error otherwise)
// PORTS
//  clk     in   1      clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  dat1    in   WIDTH  multiplicand A, requires A < mod; latched on accepted start
//  dat2    in   WIDTH  multiplier B, requires B < mod; latched on accepted start
//  mod     in   WIDTH  modulus M, must be odd; latched on accepted start
//  busy    out  1      high from accepted start until the edge that raises done
//  done    out  1      one-cycle pulse: result/err valid
//  err     out  1      set with done if latched M was even; held until next accepted start
//  result  out  WIDTH  product; held stable from done until the next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, result=0; accumulator/counter cleared.
//  States: IDLE -> CALC -> FINAL -> IDLE.
//  IDLE: on an edge with start=1, latch A,B,M; S=0; cnt=0; busy=1; err=0.
//    If M[0]==0, go directly to FINAL with the error flag set; otherwise go to CALC.
//  CALC: each edge performs UNROLL radix-2 steps, for i = cnt*UNROLL .. cnt*UNROLL+UNROLL-1:
//    S = S + A[i]*B; if S odd then S = S + M; S = S >> 1.
//    S is WIDTH+2 bits wide; the invariant S < 2M holds and no carry is ever lost.
//    After WIDTH/UNROLL edges, go to FINAL.
//  FINAL (one edge):
//    result = (S >= M) ? S-M : S (WIDTH bits); on the even-M path result = 0 and err = 1.
//    done = 1 for exactly this one cycle; busy = 0; state = IDLE.
//  Latency from the start-accepting edge to done high:
//    WIDTH/UNROLL+1 cycles for odd M; 1 cycle for even M.
//  A new start is accepted in the cycle where done is high; back-to-back throughput is one
//  op per WIDTH/UNROLL+2 cycles.
//  start while busy: ignored, with no queueing. Operand inputs may change freely after an
//  accepted start.
//  Operands >= M: out of contract. Result is undefined but the FSM must still finish with
//  the same latency.
//  Reset mid-operation: the operation is aborted immediately; outputs return to their reset
//  values and no done is issued.
// TESTING
//  T1  WIDTH=8,UNROLL=1: A=5,B=7,M=13 -> result=1, done 9 cycles after start, err=0
//  T2  WIDTH=8,UNROLL=4: same operands -> result=1, done after 3 cycles; run UNROLL=2,8 too
//  T3  WIDTH=8: A=B=254,M=255 -> result=1 (final subtract exercised); A=B=0,M=13 -> result=0
//  T4  WIDTH=8: M=12 -> done after 1 cycle, err=1, result=0; next valid op clears err
//  T5  start pulsed during CALC with new operands -> ignored; original result; busy stays high
//  T6  rst_n low mid-CALC -> busy/done/result=0 at once; then a fresh op completes correctly
//  T7  WIDTH=64 random odd M, A,B<M, 1000 ops -> match reference A*B*inv(2^64) mod M

Source files
------------

// File: rtl/modmulti_iter.sv
// modmulti_iter: iterative Montgomery multiplier, result = dat1*dat2*2^-WIDTH mod mod
module modmulti_iter #(
    parameter int WIDTH  = 2048,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dat1,
    input  logic [WIDTH-1:0] dat2,
    input  logic [WIDTH-1:0] mod,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    localparam int STEPS = WIDTH / UNROLL;
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH % UNROLL != 0) begin : g_bad_unroll
        $error("WIDTH must be a multiple of UNROLL");
    end

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH+1:0] s_q, s_nxt, b_ext, m_ext;
    logic [CW-1:0]    cnt;

    assign b_ext = {2'b0, b_q};
    assign m_ext = {2'b0, m_q};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: an even modulus skips CALC and reports through FINAL
    always_comb begin
        state_nxt = (state == IDLE) ? (start ? (mod[0] ? CALC : FINAL) : IDLE) :
                    (state == CALC) ? ((cnt == LAST) ? FINAL : CALC) : IDLE;
    end

    // outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // UNROLL radix-2 Montgomery steps; A is shifted down so its low bits are the current digits
    always_comb begin
        s_nxt = s_q;
        for (int k = 0; k < UNROLL; k++) begin
            s_nxt = s_nxt + (a_q[k] ? b_ext : '0);
            s_nxt = (s_nxt + (s_nxt[0] ? m_ext : '0)) >> 1;
        end
    end

    // operand latch, accumulator, final conditional subtract and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            s_q    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= (state == FINAL);
            if (state == IDLE && start) begin
                a_q <= dat1;
                b_q <= dat2;
                m_q <= mod;
                s_q <= '0;
                cnt <= '0;
                err <= 1'b0;
            end else if (state == CALC) begin
                s_q <= s_nxt;
                a_q <= a_q >> UNROLL;
                cnt <= cnt + CW'(1);
            end else if (state == FINAL) begin
                result <= !m_q[0] ? '0 :
                          (s_q >= m_ext) ? WIDTH'(s_q - m_ext) : s_q[WIDTH-1:0];
                err    <= ~m_q[0];
            end
        end
    end
endmodule

// File: tb/tb_modmulti_iter.sv
// tb_modmulti_iter: scoreboard bench for an 8-bit radix-2 and a 64-bit 4-step instance
module tb_modmulti_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, m8 = '0, res8;
    logic        busy8, done8, err8;
    logic        start64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0, m64 = '0, res64;
    logic        busy64, done64, err64;

    modmulti_iter #(.WIDTH(8), .UNROLL(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dat1(a8), .dat2(b8), .mod(m8),
        .busy(busy8), .done(done8), .err(err8), .result(res8)
    );

    modmulti_iter #(.WIDTH(64), .UNROLL(4)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .dat1(a64), .dat2(b64), .mod(m64),
        .busy(busy64), .done(done64), .err(err64), .result(res64)
    );

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];
    int n_cmp = 0;
    int n_bad = 0;
    int lat8 = 0;
    int lat64 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // independent reference: reduce the full product, then halve mod M 64 times
    function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] m);
        logic [127:0] p;
        logic [64:0]  x;
        p = (128'(a) * 128'(b)) % 128'(m);
        x = 65'(p);
        for (int i = 0; i < 64; i++) x = x[0] ? (x + 65'(m)) >> 1 : x >> 1;
        return x[63:0];
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] r, input logic e);
        int t = 0;
        @(negedge clk);
        while (busy8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy8) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait8: busy stuck high, expected low");
        end
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        q8.push_back('{res: 64'(r), err: e, lat: m[0] ? 9 : 1});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                        input logic [63:0] r);
        int t = 0;
        @(negedge clk);
        while (busy64 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait64: busy stuck high, expected low");
        end
        a64 = a; b64 = b; m64 = m; start64 = 1'b1;
        q64.push_back('{res: r, err: ~m[0], lat: m[0] ? 17 : 1});
        @(negedge clk);
        start64 = 1'b0;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; m64 = {$urandom, $urandom};
    endtask

    // monitor for the 8-bit instance: busy cycles before done give the latency
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) lat8 = 0;
        else begin
            if (busy8) lat8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done8: got unexpected done, expected none");
                end else begin
                    x = q8.pop_front();
                    chk("result8", res8, x.res);
                    chk("err8", err8, 64'(x.err));
                    chk("latency8", lat8, x.lat);
                    chk("busy_at_done8", busy8, 0);
                end
                lat8 = 0;
            end
        end
    end

    // monitor for the 64-bit instance
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) lat64 = 0;
        else begin
            if (busy64) lat64++;
            if (done64) begin
                if (q64.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done64: got unexpected done, expected none");
                end else begin
                    x = q64.pop_front();
                    chk("result64", res64, x.res);
                    chk("err64", err64, 64'(x.err));
                    chk("latency64", lat64, x.lat);
                end
                lat64 = 0;
            end
        end
    end

    initial begin
        logic [63:0] m, a, b;
        int t;
        repeat (2) @(negedge clk);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_err8", err8, 0);
        chk("rst_result8", res8, 0);
        chk("rst_busy64", busy64, 0);
        chk("rst_result64", res64, 0);
        #2 rst_n = 1'b1;

        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        op8(8'd254, 8'd254, 8'd255, 8'd1, 1'b0);
        op8(8'd0, 8'd0, 8'd13, 8'd0, 1'b0);
        op8(8'd1, 8'd1, 8'd13, 8'd3, 1'b0);
        op8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0);
        op8(8'd100, 8'd200, 8'd251, 8'd235, 1'b0);
        repeat (12) @(negedge clk);
        chk("result_hold8", res8, 235);

        op8(8'd3, 8'd4, 8'd12, 8'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_hold8", err8, 1);
        chk("err_result8", res8, 0);
        op8(8'd3, 8'd5, 8'd7, 8'd2, 1'b0);

        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; m8 = 8'd12; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("busy_ignore8", busy8, 1);

        op8(8'd5, 8'd7, 8'd13, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy8", busy8, 0);
        chk("abort_done8", done8, 0);
        chk("abort_result8", res8, 0);
        q8.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        op8(8'd12, 8'd12, 8'd13, 8'd3, 1'b0);

        op64(64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd6);
        op64(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        op64(64'd0, 64'd123, 64'hFFFF_FFFF_FFFF_FFC5, 64'd0);
        op64(64'd5, 64'd7, 64'd100, 64'd0);
        for (int i = 0; i < 200; i++) begin
            m = {$urandom, $urandom} | 64'h1;
            if (m < 3) m = 64'd3;
            a = {$urandom, $urandom} % m;
            b = {$urandom, $urandom} % m;
            op64(a, b, m, ref64(a, b, m));
        end

        t = 0;
        while ((q8.size() != 0 || q64.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain8", 64'(q8.size()), 0);
        chk("drain64", 64'(q64.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
